// File: rtl/envelope_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Package : env_defs
// Brief   : Shared phase encodings and gain-code constants for the envelope
// Rev     : 1.0
// ============================================================================
package env_defs;

    localparam int GAIN_W       = 4;
    localparam int GAIN_MAX_DEF = 8;

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_ATTACK = 2'd1,
        PH_HOLD   = 2'd2,
        PH_DECAY  = 2'd3
    } phase_e;

endpackage
`default_nettype wire

// File: rtl/envelope_scheduler_step_timer.sv
`default_nettype none
// ============================================================================
// Module : step_timer
// Brief  : Beat counter that flags the terminal beat of a programmable step
// Rev    : 1.0
// ============================================================================
module step_timer #(
    parameter int CNT_W = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             beat,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] step_len,
    output logic             step_done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_last;

    // step_len is never 0, so step_len-1 cannot underflow
    assign at_last   = (cnt_q == (step_len - CNT_W'(1)));
    assign step_done = en & beat & ~clr & at_last;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && beat) begin
            cnt_d = at_last ? '0 : (cnt_q + CNT_W'(1));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/envelope_scheduler.sv
`default_nettype none
// ============================================================================
// Module : envelope_scheduler
// Brief  : Attack/hold/decay gain sequencer for one voice, timed on beats
// Rev    : 1.0
// ============================================================================
module envelope_scheduler
    import env_defs::*;
#(
    parameter int GAIN_MAX  = GAIN_MAX_DEF,
    parameter int HOLD_MULT = 8,
    parameter int CNT_W     = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              beat,
    input  logic              new_note,
    input  logic [5:0]        note_duration,
    input  logic              done_with_note,
    output logic [GAIN_W-1:0] gain,
    output logic [1:0]        phase,
    output logic              busy,
    output logic              env_done
);

    localparam int                K_W        = $clog2(GAIN_MAX);
    localparam logic [GAIN_W-1:0] C_GAIN_MAX = GAIN_W'(GAIN_MAX);

    phase_e            phase_q, phase_d;
    logic [GAIN_W-1:0] gain_q, gain_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [5:0]        dur_q, dur_d;
    logic              busy_q, busy_d;
    logic              env_done_q, env_done_d;

    logic [CNT_W-1:0]  dur_ext;
    logic [CNT_W-1:0]  step_len;
    logic              step_done;
    logic              timer_clr;
    logic              timer_en;

    assign dur_ext   = CNT_W'(dur_q);
    assign timer_clr = new_note | done_with_note;
    assign timer_en  = (phase_q != PH_IDLE);

    always_comb begin
        step_len = dur_ext;
        case (phase_q)
            PH_HOLD:  step_len = dur_ext * CNT_W'(HOLD_MULT);
            PH_DECAY: step_len = dur_ext << k_q;
            default:  step_len = dur_ext;
        endcase
    end

    step_timer #(
        .CNT_W (CNT_W)
    ) u_step_timer (
        .clk       (clk),
        .reset     (reset),
        .beat      (beat),
        .clr       (timer_clr),
        .en        (timer_en),
        .step_len  (step_len),
        .step_done (step_done)
    );

    always_comb begin
        phase_d    = phase_q;
        gain_d     = gain_q;
        k_d        = k_q;
        dur_d      = dur_q;
        env_done_d = 1'b0;

        // new_note outranks done_with_note and any step completion
        if (new_note) begin
            dur_d   = (note_duration == 6'd0) ? 6'd1 : note_duration;
            phase_d = PH_ATTACK;
            gain_d  = '0;
            k_d     = '0;
        end else if (done_with_note) begin
            phase_d = PH_IDLE;
            gain_d  = '0;
            k_d     = '0;
        end else if (step_done) begin
            case (phase_q)
                PH_ATTACK: begin
                    if (gain_q < C_GAIN_MAX) begin
                        gain_d = gain_q + GAIN_W'(1);
                    end
                    if (gain_q >= (C_GAIN_MAX - GAIN_W'(1))) begin
                        phase_d = PH_HOLD;
                    end
                end
                PH_HOLD: begin
                    phase_d = PH_DECAY;
                    k_d     = '0;
                end
                PH_DECAY: begin
                    if (gain_q != '0) begin
                        gain_d = gain_q - GAIN_W'(1);
                    end
                    k_d = k_q + K_W'(1);
                    if (gain_q <= GAIN_W'(1)) begin
                        phase_d    = PH_IDLE;
                        gain_d     = '0;
                        k_d        = '0;
                        env_done_d = 1'b1;
                    end
                end
                default: begin
                    phase_d = PH_IDLE;
                end
            endcase
        end

        busy_d = (phase_d != PH_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q    <= PH_IDLE;
            gain_q     <= '0;
            k_q        <= '0;
            dur_q      <= 6'd1;
            busy_q     <= 1'b0;
            env_done_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            gain_q     <= gain_d;
            k_q        <= k_d;
            dur_q      <= dur_d;
            busy_q     <= busy_d;
            env_done_q <= env_done_d;
        end
    end

    assign gain     = gain_q;
    assign phase    = phase_q;
    assign busy     = busy_q;
    assign env_done = env_done_q;

endmodule
`default_nettype wire

// File: tb/tb_envelope_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_envelope_scheduler
// Brief  : Self-checking bench for envelope_scheduler (vector table + sequences)
// Rev    : 1.0
// ============================================================================
module tb_envelope_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       beat = 1'b0;
    logic       new_note = 1'b0;
    logic [5:0] note_duration = 6'd0;
    logic       done_with_note = 1'b0;
    logic [3:0] gain;
    logic [1:0] phase;
    logic       busy;
    logic       env_done;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic       bt;
        logic       nn;
        logic       dn;
        logic [5:0] dur;
        int         eg;
        int         ep;
        int         ed;
    } vec_t;

    vec_t tbl[64];
    int   ntbl = 0;

    envelope_scheduler dut (
        .clk            (clk),
        .reset          (reset),
        .beat           (beat),
        .new_note       (new_note),
        .note_duration  (note_duration),
        .done_with_note (done_with_note),
        .gain           (gain),
        .phase          (phase),
        .busy           (busy),
        .env_done       (env_done)
    );

    always #5 clk = ~clk;

    task automatic add(input logic bt, input logic nn, input logic dn,
                       input logic [5:0] dur, input int eg, input int ep, input int ed);
        tbl[ntbl].bt  = bt;
        tbl[ntbl].nn  = nn;
        tbl[ntbl].dn  = dn;
        tbl[ntbl].dur = dur;
        tbl[ntbl].eg  = eg;
        tbl[ntbl].ep  = ep;
        tbl[ntbl].ed  = ed;
        ntbl++;
    endtask

    task automatic check(input string nm, input int eg, input int ep, input int ed);
        logic eb;
        eb = (ep != 0);
        n_chk++;
        if (gain !== 4'(eg) || phase !== 2'(ep) || busy !== eb || env_done !== 1'(ed)) begin
            n_err++;
            $display("FAIL %s: got gain=%0d phase=%0d busy=%0d env_done=%0d, expected gain=%0d phase=%0d busy=%0d env_done=%0d",
                     nm, gain, phase, busy, env_done, eg, ep, eb, ed);
        end
    endtask

    // Inputs change 1 time unit after the active edge; outputs are sampled there too.
    task automatic cyc(input logic bt, input logic nn, input logic dn, input logic [5:0] dur);
        beat           = bt;
        new_note       = nn;
        done_with_note = dn;
        note_duration  = dur;
        @(posedge clk);
        #1;
        beat           = 1'b0;
        new_note       = 1'b0;
        done_with_note = 1'b0;
    endtask

    // Start a note and walk the whole envelope one beat per cycle, checking
    // every cycle against the expected schedule. limit>0 stops after that many beats.
    task automatic run_env(input int dur, input int limit);
        int d;
        int nb;
        int len;
        bit last;
        d  = (dur == 0) ? 1 : dur;
        nb = 0;
        cyc(1'b0, 1'b1, 1'b0, 6'(dur));
        check($sformatf("start d=%0d", dur), 0, 1, 0);
        for (int i = 1; i <= 8; i++) begin
            for (int j = 1; j <= d; j++) begin
                cyc(1'b1, 1'b0, 1'b0, 6'd0);
                nb++;
                last = (j == d);
                check($sformatf("attack d=%0d step=%0d beat=%0d", dur, i, j),
                      last ? i : i - 1, (last && i == 8) ? 2 : 1, 0);
                if (limit > 0 && nb >= limit) return;
            end
        end
        for (int j = 1; j <= 8 * d; j++) begin
            cyc(1'b1, 1'b0, 1'b0, 6'd0);
            nb++;
            check($sformatf("hold d=%0d beat=%0d", dur, j), 8, (j == 8 * d) ? 3 : 2, 0);
            if (limit > 0 && nb >= limit) return;
        end
        for (int s = 0; s < 8; s++) begin
            len = d << s;
            for (int j = 1; j <= len; j++) begin
                cyc(1'b1, 1'b0, 1'b0, 6'd0);
                nb++;
                last = (j == len);
                check($sformatf("decay d=%0d step=%0d beat=%0d", dur, s, j),
                      last ? 7 - s : 8 - s, (last && s == 7) ? 0 : 3, (last && s == 7) ? 1 : 0);
                if (limit > 0 && nb >= limit) return;
            end
        end
        cyc(1'b0, 1'b0, 1'b0, 6'd0);
        check($sformatf("post_done d=%0d", dur), 0, 0, 0);
        cyc(1'b1, 1'b0, 1'b0, 6'd0);
        check($sformatf("idle_beat d=%0d", dur), 0, 0, 0);
    endtask

    initial begin
        // Vector table: idle behaviour, collisions and quick restarts
        for (int i = 0; i < 20; i++) add(1'b1, 1'b0, 1'b0, 6'd0, 0, 0, 0);
        add(1'b0, 1'b0, 1'b1, 6'd0, 0, 0, 0);   // abort while idle
        add(1'b0, 1'b1, 1'b1, 6'd2, 0, 1, 0);   // new_note beats done_with_note
        add(1'b1, 1'b0, 1'b0, 6'd0, 0, 1, 0);
        add(1'b1, 1'b0, 1'b0, 6'd0, 1, 1, 0);
        add(1'b0, 1'b0, 1'b1, 6'd0, 0, 0, 0);   // abort in attack
        add(1'b1, 1'b0, 1'b0, 6'd0, 0, 0, 0);
        add(1'b1, 1'b1, 1'b0, 6'd0, 0, 1, 0);   // duration 0 acts as 1
        add(1'b1, 1'b0, 1'b0, 6'd0, 1, 1, 0);
        add(1'b1, 1'b0, 1'b0, 6'd0, 2, 1, 0);
        add(1'b0, 1'b0, 1'b1, 6'd0, 0, 0, 0);

        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset", 0, 0, 0);
        reset = 1'b1;

        for (int i = 0; i < ntbl; i++) begin
            cyc(tbl[i].bt, tbl[i].nn, tbl[i].dn, tbl[i].dur);
            check($sformatf("tbl[%0d]", i), tbl[i].eg, tbl[i].ep, tbl[i].ed);
        end

        run_env(2, 0);
        run_env(0, 0);

        // Abort at gain 5 in attack
        run_env(3, 15);
        cyc(1'b0, 1'b0, 1'b1, 6'd0);
        check("abort", 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 6'd0);
            check($sformatf("abort_idle%0d", i), 0, 0, 0);
        end

        // Retrigger at gain 4 in decay; the coincident beat must not count
        run_env(1, 31);
        cyc(1'b1, 1'b1, 1'b0, 6'd2);
        check("retrig", 0, 1, 0);
        cyc(1'b1, 1'b0, 1'b0, 6'd0);
        check("retrig_b1", 0, 1, 0);
        cyc(1'b1, 1'b0, 1'b0, 6'd0);
        check("retrig_b2", 1, 1, 0);
        cyc(1'b1, 1'b1, 1'b1, 6'd2);
        check("collide", 0, 1, 0);
        cyc(1'b1, 1'b0, 1'b0, 6'd0);
        check("collide_b1", 0, 1, 0);
        cyc(1'b1, 1'b0, 1'b0, 6'd0);
        check("collide_b2", 1, 1, 0);

        // Longest note: final decay step is 8064 beats
        run_env(63, 0);

        // Async reset partway through the final decay step, between edges
        run_env(63, 13009);
        #3;
        reset = 1'b0;
        #1;
        check("async_reset", 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 6'd0);
            check($sformatf("post_reset%0d", i), 0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
